// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV64I multi-cycle controller: states, ALU ops,
// opcode/funct constants and trap causes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_ILLEGAL = 2'd1,
      CAUSE_TIMEOUT = 2'd2
   } cause_t;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SR     = 3'b101;
   localparam logic [2:0] F3_D      = 3'b011;
   localparam logic [2:0] F3_BEQ    = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   // Immediate shifts: upper six funct7 bits only, bit 0 is shamt[5]
   localparam logic [5:0] F6_BASE = 6'b000000;
   localparam logic [5:0] F6_ALT  = 6'b010000;

   function automatic logic [3:0] baseAluOp(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the shared
// datapath / fetch unit (slave).
interface multicycle_ctrl_if;
   logic        instr_valid;
   logic [31:0] instr;
   logic        alu_zero;
   logic        mem_ready;
   logic        instr_ready;
   logic        rf_read_en;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [3:0]  alu_op;
   logic        alu_src;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        reg_write;
   logic        pc_write;
   logic        pc_src;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [2:0]  state;
   logic [63:0] instret;

   modport master (
      input  instr_valid, instr, alu_zero, mem_ready,
      output instr_ready, rf_read_en, rs1, rs2, rd, alu_op, alu_src,
             mem_read, mem_write, mem_to_reg, reg_write, pc_write, pc_src,
             trap, trap_cause, state, instret
   );

   modport slave (
      output instr_valid, instr, alu_zero, mem_ready,
      input  instr_ready, rf_read_en, rs1, rs2, rd, alu_op, alu_src,
             mem_read, mem_write, mem_to_reg, reg_write, pc_write, pc_src,
             trap, trap_cause, state, instret
   );
endinterface

// File: rtl/alu_decode.sv
// Combinational RV64I decode of {opcode, funct3, funct7} into ALU op, operand
// select and legality; zero latency, no handshake.
module alu_decode
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic [3:0] aluOp,
   output logic       aluSrc,
   output logic       legal
);

   always_comb begin
      aluOp  = ALU_ADD;
      aluSrc = 1'b0;
      legal  = 1'b0;
      case (opcode)
         OP_R: begin
            aluOp = baseAluOp(funct3);
            if (funct7 == F7_BASE) begin
               legal = 1'b1;
            end else if (funct7 == F7_ALT && (funct3 == F3_ADDSUB || funct3 == F3_SR)) begin
               legal = 1'b1;
               aluOp = (funct3 == F3_ADDSUB) ? ALU_SUB : ALU_SRA;
            end
         end
         OP_IMM: begin
            aluSrc = 1'b1;
            aluOp  = baseAluOp(funct3);
            case (funct3)
               F3_SLL: legal = (funct7[6:1] == F6_BASE);
               F3_SR: begin
                  if (funct7[6:1] == F6_BASE) begin
                     legal = 1'b1;
                  end else if (funct7[6:1] == F6_ALT) begin
                     legal = 1'b1;
                     aluOp = ALU_SRA;
                  end
               end
               default: legal = 1'b1;
            endcase
         end
         OP_LOAD, OP_STORE: begin
            aluSrc = 1'b1;
            legal  = (funct3 == F3_D);
         end
         OP_BRANCH: begin
            aluOp = ALU_SUB;
            legal = (funct3 == F3_BEQ);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Sequences one RV64I instruction at a time: 3 cycles BEQ, 4 R/I/SD, 5+ LD.
// Accepts instr only in FETCH; MEM waits for mem_ready up to MEM_TIMEOUT cycles.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
)
(
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master bus
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

   state_t          curState;
   cause_t          cause;
   logic [31:0]     ir;
   logic [63:0]     instretCnt;
   logic [CW-1:0]   waitCnt;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [3:0] decOp;
   logic       decSrc;
   logic       decLegal;
   logic       isLd;
   logic       isSd;
   logic       isBeq;
   logic       rdNonZero;

   assign opcode    = ir[6:0];
   assign funct3    = ir[14:12];
   assign funct7    = ir[31:25];
   assign isLd      = (opcode == OP_LOAD);
   assign isSd      = (opcode == OP_STORE);
   assign isBeq     = (opcode == OP_BRANCH);
   assign rdNonZero = (ir[11:7] != 5'd0);

   alu_decode uDecode (
      .opcode (opcode),
      .funct3 (funct3),
      .funct7 (funct7),
      .aluOp  (decOp),
      .aluSrc (decSrc),
      .legal  (decLegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curState   <= FETCH;
         cause      <= CAUSE_NONE;
         ir         <= '0;
         instretCnt <= '0;
         waitCnt    <= '0;
      end else begin
         case (curState)
            FETCH: begin
               if (bus.instr_valid) begin
                  ir       <= bus.instr;
                  curState <= DECODE;
               end
            end
            DECODE: begin
               if (decLegal) begin
                  curState <= EXEC;
               end else begin
                  cause    <= CAUSE_ILLEGAL;
                  curState <= TRAP;
               end
            end
            EXEC: begin
               if (isBeq) begin
                  instretCnt <= instretCnt + 64'd1;
                  curState   <= FETCH;
               end else if (isLd || isSd) begin
                  waitCnt  <= '0;
                  curState <= MEM;
               end else begin
                  curState <= WB;
               end
            end
            MEM: begin
               // Ready on the final allowed cycle still completes the access
               if (bus.mem_ready) begin
                  if (isSd) begin
                     instretCnt <= instretCnt + 64'd1;
                     curState   <= FETCH;
                  end else begin
                     curState <= WB;
                  end
               end else if (waitCnt == WAIT_LAST) begin
                  cause    <= CAUSE_TIMEOUT;
                  curState <= TRAP;
               end else begin
                  waitCnt <= waitCnt + CW'(1);
               end
            end
            WB: begin
               instretCnt <= instretCnt + 64'd1;
               curState   <= FETCH;
            end
            TRAP: curState <= TRAP;
            default: curState <= FETCH;
         endcase
      end
   end

   assign bus.instr_ready = (curState == FETCH);
   assign bus.rf_read_en  = (curState == DECODE);
   assign bus.rs1         = ir[19:15];
   assign bus.rs2         = ir[24:20];
   assign bus.rd          = ir[11:7];
   assign bus.alu_op      = (curState == EXEC) ? decOp : ALU_ADD;
   assign bus.alu_src     = (curState == EXEC) && decSrc;
   assign bus.mem_read    = (curState == MEM) && isLd;
   assign bus.mem_write   = (curState == MEM) && isSd;
   assign bus.mem_to_reg  = (curState == WB) && isLd;
   assign bus.reg_write   = (curState == WB) && rdNonZero;
   assign bus.pc_write    = ((curState == EXEC) && isBeq) ||
                            ((curState == MEM) && isSd && bus.mem_ready) ||
                            (curState == WB);
   assign bus.pc_src      = (curState == EXEC) && isBeq && bus.alu_zero;
   assign bus.trap        = (curState == TRAP);
   assign bus.trap_cause  = cause;
   assign bus.state       = curState;
   assign bus.instret     = instretCnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction expectations (latency,
// strobe counts, ALU op from mnemonic tables) compared against observed activity.
module tb_multicycle_ctrl;

   localparam int TMO   = 16;
   localparam int K_ALU = 0;
   localparam int K_LD  = 1;
   localparam int K_SD  = 2;
   localparam int K_BEQ = 3;
   localparam int K_ILL = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int checks = 0;
   int errors = 0;
   logic [63:0] expInstret = 64'd0;

   // mnemonic tables: R-type ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
   logic [2:0] rF3 [10] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111};
   logic [6:0] rF7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
   logic [3:0] rOp [10] = '{4'd0, 4'd1, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd7, 4'd3, 4'd2};
   // I-type ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
   logic [2:0] iF3 [9] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111, 3'b001, 3'b101, 3'b101};
   logic [3:0] iOp [9] = '{4'd0, 4'd8, 4'd9, 4'd4, 4'd3, 4'd2, 4'd5, 4'd6, 4'd7};
   logic [5:0] iHi [9] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'b000000, 6'b000000, 6'b010000};
   logic [31:0] illList [7] = '{32'h00000000, 32'h022081B3, 32'h0081A283, 32'h00209463,
                                32'h0000006F, 32'h402091B3, 32'h40109193};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] strobes();
      return {bus.rf_read_en, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_write,
              bus.pc_write, bus.pc_src, bus.alu_src, bus.trap, bus.alu_op};
   endfunction

   task automatic doReset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      bus.instr_valid = 1'b0;
      bus.mem_ready   = 1'b0;
      #1;
      check("rst_state",   bus.state, 0);
      check("rst_ready",   bus.instr_ready, 1);
      check("rst_cause",   bus.trap_cause, 0);
      check("rst_instret", bus.instret, 0);
      check("rst_strobes", strobes(), 0);
      check("rst_ir",      {bus.rs1, bus.rs2, bus.rd}, 0);
      expInstret = 64'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // d: MEM cycle index (0-based) on which mem_ready rises; d >= TMO never completes
   task automatic runOne(input logic [31:0] w, input int kind, input logic [3:0] expOp,
                         input logic expSrc, input int d, input logic zero, input string tag);
      int expLat, eMemR, eMemW, eM2r, eRegW, ePcW, eRet, eTrap, eCause;
      int obsLat, nRf, nMemR, nMemW, nM2r, nRegW, nPcW;
      logic ePcSrc, pcSrcSeen, srcSeen;
      logic [3:0] opSeen;
      logic [4:0] wrd, rdSeen;
      bit isMem;
      wrd = w[11:7];
      isMem = (kind == K_LD) || (kind == K_SD);
      eMemR = 0; eMemW = 0; eM2r = 0; eRegW = 0; ePcW = 0; eRet = 0; eTrap = 0; eCause = 0;
      ePcSrc = 1'b0;
      case (kind)
         K_ALU: begin expLat = 4; eRegW = (wrd != 0); ePcW = 1; eRet = 1; end
         K_BEQ: begin expLat = 3; ePcW = 1; ePcSrc = zero; eRet = 1; end
         K_ILL: begin expLat = 2; eTrap = 1; eCause = 1; end
         default: begin
            if (d >= TMO) begin
               expLat = 3 + TMO; eTrap = 1; eCause = 2;
               if (kind == K_LD) eMemR = TMO; else eMemW = TMO;
            end else if (kind == K_LD) begin
               expLat = 5 + d; eMemR = d + 1; eM2r = 1; eRegW = (wrd != 0); ePcW = 1; eRet = 1;
            end else begin
               expLat = 4 + d; eMemW = d + 1; ePcW = 1; eRet = 1;
            end
         end
      endcase

      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = w;
      bus.alu_zero    = zero;
      bus.mem_ready   = 1'($urandom);
      #1 check({tag, "_hs"}, bus.instr_ready, 1);

      obsLat = 0; nRf = 0; nMemR = 0; nMemW = 0; nM2r = 0; nRegW = 0; nPcW = 0;
      pcSrcSeen = 1'b0; srcSeen = 1'b0; opSeen = 4'd0; rdSeen = 5'd0;
      for (int c = 1; c <= 40 && obsLat == 0; c++) begin
         @(negedge clk);
         bus.instr_valid = (c < expLat) ? 1'($urandom) : 1'b0;
         bus.instr       = $urandom;
         if (isMem && c >= 3 && c - 3 <= d) bus.mem_ready = (c - 3 == d);
         else                               bus.mem_ready = 1'($urandom);
         #1;
         nRf   += int'(bus.rf_read_en);
         nMemR += int'(bus.mem_read);
         nMemW += int'(bus.mem_write);
         nM2r  += int'(bus.mem_to_reg);
         nRegW += int'(bus.reg_write);
         nPcW  += int'(bus.pc_write);
         if (c == 2) begin opSeen = bus.alu_op; srcSeen = bus.alu_src; end
         if (bus.pc_write)  pcSrcSeen = pcSrcSeen | bus.pc_src;
         if (bus.reg_write) rdSeen = bus.rd;
         if (bus.instr_ready || bus.trap) obsLat = c;
      end
      bus.instr_valid = 1'b0;
      expInstret += 64'(eRet);

      check({tag, "_latency"}, obsLat, expLat);
      check({tag, "_rf_read"}, nRf, 1);
      check({tag, "_alu_op"},  opSeen, expOp);
      check({tag, "_alu_src"}, srcSeen, expSrc);
      check({tag, "_mem_rd"},  nMemR, eMemR);
      check({tag, "_mem_wr"},  nMemW, eMemW);
      check({tag, "_m2r"},     nM2r, eM2r);
      check({tag, "_reg_wr"},  nRegW, eRegW);
      check({tag, "_pc_wr"},   nPcW, ePcW);
      check({tag, "_pc_src"},  pcSrcSeen, ePcSrc);
      check({tag, "_trap"},    bus.trap, eTrap);
      check({tag, "_cause"},   bus.trap_cause, eCause);
      check({tag, "_instret"}, bus.instret, expInstret);
      if (eRegW != 0) check({tag, "_rd"}, rdSeen, wrd);
   endtask

   task automatic trapHold(input logic [1:0] cause);
      repeat (4) begin
         @(negedge clk);
         bus.instr_valid = 1'b1;
         bus.instr       = 32'h002081B3;
         bus.mem_ready   = 1'($urandom);
      end
      #1;
      check("trap_state",   bus.state, 5);
      check("trap_ready",   bus.instr_ready, 0);
      check("trap_cause",   bus.trap_cause, cause);
      check("trap_instret", bus.instret, expInstret);
      bus.instr_valid = 1'b0;
   endtask

   task automatic genRandom();
      int cat, i;
      logic [4:0] r1, r2, rdv;
      logic [6:0] f7;
      logic z;
      cat = $urandom_range(0, 4);
      r1  = 5'($urandom);
      r2  = 5'($urandom);
      rdv = 5'($urandom);
      z   = 1'($urandom);
      case (cat)
         0: begin
            i = $urandom_range(0, 9);
            runOne({rF7[i], r2, r1, rF3[i], rdv, 7'b0110011}, K_ALU, rOp[i], 1'b0, 0, z, "rnd_r");
         end
         1: begin
            i = $urandom_range(0, 8);
            if (i < 6) f7 = 7'($urandom);
            else       f7 = {iHi[i], 1'($urandom)};
            runOne({f7, r2, r1, iF3[i], rdv, 7'b0010011}, K_ALU, iOp[i], 1'b1, 0, z, "rnd_i");
         end
         2: runOne({12'($urandom), r1, 3'b011, rdv, 7'b0000011}, K_LD, 4'd0, 1'b1,
                   $urandom_range(0, 4), z, "rnd_ld");
         3: runOne({7'($urandom), r2, r1, 3'b011, 5'($urandom), 7'b0100011}, K_SD, 4'd0, 1'b1,
                   $urandom_range(0, 4), z, "rnd_sd");
         default: runOne({7'($urandom), r2, r1, 3'b000, 5'($urandom), 7'b1100011}, K_BEQ,
                         4'd1, 1'b0, 0, z, "rnd_beq");
      endcase
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = 32'h0;
      bus.alu_zero    = 1'b0;
      bus.mem_ready   = 1'b0;
      doReset();

      runOne(32'h002081B3, K_ALU, 4'd0, 1'b0, 0,       1'b0, "add");
      runOne(32'h00813283, K_LD,  4'd0, 1'b1, 2,       1'b0, "ld");
      runOne(32'h00513823, K_SD,  4'd0, 1'b1, 0,       1'b0, "sd");
      runOne(32'h00208463, K_BEQ, 4'd1, 1'b0, 0,       1'b1, "beq");
      runOne(32'h00208463, K_BEQ, 4'd1, 1'b0, 0,       1'b0, "beq_nt");
      runOne(32'h00208033, K_ALU, 4'd0, 1'b0, 0,       1'b1, "add_x0");
      runOne(32'h00813283, K_LD,  4'd0, 1'b1, TMO - 1, 1'b0, "ld_last");
      runOne(32'h00513823, K_SD,  4'd0, 1'b1, TMO - 1, 1'b0, "sd_last");

      repeat (40) genRandom();

      runOne(32'h00813283, K_LD, 4'd0, 1'b1, 1000, 1'b0, "ld_tmo");
      trapHold(2'd2);
      doReset();
      runOne(32'h00513823, K_SD, 4'd0, 1'b1, 1000, 1'b0, "sd_tmo");
      trapHold(2'd2);
      doReset();

      foreach (illList[k]) begin
         runOne(illList[k], K_ILL, 4'd0, 1'b0, 0, 1'b0, "illegal");
         trapHold(2'd1);
         doReset();
      end

      // reset while an LD waits in MEM
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = 32'h00813283;
      bus.mem_ready   = 1'b0;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1 check("midmem_rd_before", bus.mem_read, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midmem_rd_after", bus.mem_read, 0);
      check("midmem_state",    bus.state, 0);
      check("midmem_instret",  bus.instret, expInstret);
      @(negedge clk);
      rst_n = 1'b1;
      runOne(32'h002081B3, K_ALU, 4'd0, 1'b0, 0, 1'b0, "recover");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
